instruction_fetch: RTL

Fetch stage directly downstream of programCounter in the multi-cycle core. It takes the current PC and issues a single outstanding read to instruction memory over a req/gnt + rvalid handshake. It captures the returned word into the instruction register (IR) for decode. It pulses pc_write so programCounter advances by 4, and reports misaligned, bus-error and timeout faults.

---
 rtl/instruction_fetch.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage of the multi-cycle core. Takes the current PC, issues a single
//   outstanding read to instruction memory (req/gnt + rvalid), captures the
//   returned word into the instruction register and pulses pc_write so the
//   program counter advances. Misaligned PCs, bus errors and response
//   timeouts are reported as a held fault until a flush.
//
// Ports
//   clk          core clock, rising edge
//   rst          asynchronous active-low reset
//   fetch_en     control FSM requests a fetch of pc
//   pc           current PC from programCounter
//   flush        redirect; discard any in-flight or held fetch
//   imem_req     read request to instruction memory
//   imem_addr    word-aligned read address
//   imem_gnt     memory accepts the request this cycle
//   imem_rvalid  read data / error valid this cycle
//   imem_rdata   read data
//   imem_err     bus error, qualified by imem_rvalid
//   ir           captured instruction
//   ir_pc        address the instruction in ir was fetched from
//   ir_valid     ir holds an unconsumed instruction
//   ir_ready     decode consumes ir this cycle
//   pc_write     one-cycle pulse to programCounter PCWrite
//   fetch_fault  fault held
//   fault_cause  00 none, 01 misaligned, 10 bus error, 11 timeout
//   busy         FSM not in IDLE
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] START_ADDRESS  = 32'h0100_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic        pc_write,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause,
  output logic        busy
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned TW   = 8;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_FULL  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    C_NONE     = 2'b00,
    C_MISALIGN = 2'b01,
    C_BUS      = 2'b10,
    C_TIMEOUT  = 2'b11
  } cause_t;

  state_t          state_q, state_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] ir_pc_q, ir_pc_d;
  logic            ir_valid_q, ir_valid_d;
  logic            pc_write_q, pc_write_d;
  logic            fault_q, fault_d;
  cause_t          cause_q, cause_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            discard_q, discard_d;
  logic            busy_q, busy_d;

  logic misaligned;
  assign misaligned = |pc[1:0];

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      addr_q     <= START_ADDRESS;
      ir_q       <= NOP_INSTR;
      ir_pc_q    <= START_ADDRESS;
      ir_valid_q <= 1'b0;
      pc_write_q <= 1'b0;
      fault_q    <= 1'b0;
      cause_q    <= C_NONE;
      timer_q    <= '0;
      discard_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      pc_write_q <= pc_write_d;
      fault_q    <= fault_d;
      cause_q    <= cause_d;
      timer_q    <= timer_d;
      discard_q  <= discard_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    pc_write_d = 1'b0;
    fault_d    = fault_q;
    cause_d    = cause_q;
    timer_d    = timer_q;
    discard_d  = discard_q;

    case (state_q)
      S_IDLE: begin
        if (!flush && fetch_en) begin
          if (misaligned) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            cause_d = C_MISALIGN;
          end else begin
            state_d = S_REQ;
            req_d   = 1'b1;
            addr_d  = {pc[XLEN-1:2], 2'b00};
          end
        end
      end

      // Request is never withdrawn; a flush only marks the response as dead.
      S_REQ: begin
        if (flush) discard_d = 1'b1;
        if (imem_gnt) begin
          state_d = S_WAIT;
          req_d   = 1'b0;
          timer_d = '0;
        end
      end

      // Response beats timeout when both land in the same cycle.
      S_WAIT: begin
        if (imem_rvalid) begin
          if (discard_q || flush) begin
            state_d   = S_IDLE;
            discard_d = 1'b0;
          end else if (imem_err) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            cause_d = C_BUS;
          end else begin
            state_d    = S_FULL;
            ir_d       = imem_rdata;
            ir_pc_d    = addr_q;
            ir_valid_d = 1'b1;
            pc_write_d = 1'b1;
          end
        end else if (timer_q == TIMER_LAST) begin
          state_d   = S_FAULT;
          fault_d   = 1'b1;
          cause_d   = C_TIMEOUT;
          discard_d = 1'b0;
        end else begin
          timer_d = timer_q + TW'(1);
          if (flush) discard_d = 1'b1;
        end
      end

      // Hold ir until consumed; a consume with fetch_en chains straight into REQ.
      S_FULL: begin
        if (flush) begin
          state_d    = S_IDLE;
          ir_valid_d = 1'b0;
          ir_d       = NOP_INSTR;
        end else if (ir_ready) begin
          ir_valid_d = 1'b0;
          if (!fetch_en) begin
            state_d = S_IDLE;
          end else if (misaligned) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            cause_d = C_MISALIGN;
          end else begin
            state_d = S_REQ;
            req_d   = 1'b1;
            addr_d  = {pc[XLEN-1:2], 2'b00};
          end
        end
      end

      // Only a flush leaves the fault state.
      S_FAULT: begin
        ir_valid_d = 1'b0;
        req_d      = 1'b0;
        if (flush) begin
          state_d = S_IDLE;
          fault_d = 1'b0;
          cause_d = C_NONE;
        end
      end

      default: begin
        state_d    = S_IDLE;
        req_d      = 1'b0;
        ir_valid_d = 1'b0;
        fault_d    = 1'b0;
        cause_d    = C_NONE;
        discard_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign ir          = ir_q;
  assign ir_pc       = ir_pc_q;
  assign ir_valid    = ir_valid_q;
  assign pc_write    = pc_write_q;
  assign fetch_fault = fault_q;
  assign fault_cause = cause_q;
  assign busy        = busy_q;

endmodule
